// File: rtl/muskoka_uart_tx_if.sv
// Wishbone classic slave bundle for the muskoka console UART.
// The UART sits on the slave modport; the bus owner uses master.
interface muskoka_uart_tx_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/muskoka_uart_tx.sv
// Transmit-only 8N1 console UART with a Wishbone register file and a byte FIFO.
// Register map: 0 TXDATA (w), 1 STATUS (r), 2 DIVISOR (rw), 3 reserved.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line high, waiting for the FIFO to hold a byte
// START    | start bit (line low) for one bit period
// DATA     | eight data bits, LSB first, one bit period each
// STOP     | stop bit (line high); chains straight into START if queued
module muskoka_uart_tx #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 433
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   muskoka_uart_tx_if.slave       wb,
   output logic                   tx_o,
   output logic                   irq_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [1:0] ADR_TXDATA  = 2'd0;
   localparam logic [1:0] ADR_STATUS  = 2'd1;
   localparam logic [1:0] ADR_DIVISOR = 2'd2;

   logic [1:0]    state;
   logic [15:0]   timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tx_q;
   logic          irq_q;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;

   logic          ack_q;
   logic [31:0]   dat_q;
   logic [31:0]   rd_val;
   logic          ovf;
   logic [15:0]   divisor;

   logic          req;
   logic          wr_txdata;
   logic          wr_div;
   logic          rd_status;
   logic          push;
   logic          pop;
   logic          bit_done;
   logic          busy;
   logic [7:0]    count8;
   logic          unused_dat;

   assign unused_dat = ^wb.wb_dat_i[31:16];

   // A new transfer is taken only while ack is low, so a held strobe
   // produces one transfer every two cycles.
   assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wr_txdata = req &  wb.wb_we_i & (wb.wb_adr_i == ADR_TXDATA);
   assign wr_div    = req &  wb.wb_we_i & (wb.wb_adr_i == ADR_DIVISOR);
   assign rd_status = req & ~wb.wb_we_i & (wb.wb_adr_i == ADR_STATUS);

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign push       = wr_txdata & ~fifo_full;
   assign bit_done   = (timer == 16'd0);
   assign pop        = ~fifo_empty &
                       ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));
   assign busy       = (state != ST_IDLE);
   assign count8     = 8'(fifo_count);

   always_comb begin
      rd_val = 32'd0;
      case (wb.wb_adr_i)
         ADR_STATUS:  rd_val = {16'd0, count8, 4'd0, ovf, busy, fifo_full, fifo_empty};
         ADR_DIVISOR: rd_val = {16'd0, divisor};
         default:     rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
         ovf     <= 1'b0;
         divisor <= 16'(DEFAULT_DIV);
      end else begin
         ack_q <= req;
         dat_q <= (req & ~wb.wb_we_i) ? rd_val : 32'd0;
         if (wr_txdata & fifo_full)
            ovf <= 1'b1;
         else if (rd_status)
            ovf <= 1'b0;
         if (wr_div)
            divisor <= wb.wb_dat_i[15:0];
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_mem[wr_ptr] <= wb.wb_dat_i[7:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // The bit timer reloads from the divisor at every bit boundary, so a
   // divisor write only affects bits that start after it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         timer   <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state <= ST_START;
                  timer <= divisor;
                  shreg <= fifo_mem[rd_ptr];
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state   <= ST_DATA;
                  timer   <= divisor;
                  bit_idx <= 3'd0;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  timer <= divisor;
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7)
                     state <= ST_STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            default: begin
               if (bit_done) begin
                  if (pop) begin
                     state <= ST_START;
                     timer <= divisor;
                     shreg <= fifo_mem[rd_ptr];
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  timer <= timer - 16'd1;
               end
            end
         endcase
      end
   end

   // Registered line driver and interrupt keep tx_o/irq_o glitch-free.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_q  <= 1'b1;
         irq_q <= 1'b1;
      end else begin
         case (state)
            ST_START: tx_q <= 1'b0;
            ST_DATA:  tx_q <= shreg[0];
            default:  tx_q <= 1'b1;
         endcase
         irq_q <= fifo_empty & ~busy;
      end
   end

   assign tx_o  = tx_q;
   assign irq_o = irq_q;

endmodule

// File: tb/tb_muskoka_uart_tx.sv
// Directed self-checking bench for muskoka_uart_tx: register access,
// frame waveforms, back-to-back frames, overflow, divisor change, reset.
module tb_muskoka_uart_tx;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx;
   logic irq;
   int   checks = 0;
   int   failures = 0;
   logic exp_wave[$];

   muskoka_uart_tx_if wb();

   muskoka_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(433)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (wb),
      .tx_o  (tx),
      .irq_o (irq)
   );

   always #5 clk = ~clk;

   task automatic wb_xfer(input logic we, input logic [1:0] adr,
                          input logic [31:0] din, output logic [31:0] dout);
      @(negedge clk);
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_adr_i = adr;
      wb.wb_dat_i = din;
      @(posedge clk);
      #1;
      checks++;
      if (wb.wb_ack_o !== 1'b1) begin
         failures++;
         $display("FAIL wb_ack adr=%0d actual=%b required=1", adr, wb.wb_ack_o);
      end
      dout = wb.wb_dat_o;
      @(negedge clk);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] adr, input logic [31:0] din);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, din, dummy);
   endtask

   task automatic wb_read(input logic [1:0] adr, output logic [31:0] dout);
      wb_xfer(1'b0, adr, 32'd0, dout);
   endtask

   task automatic push_frame(input logic [7:0] data, input int cpb);
      for (int b = 0; b < 10; b++) begin
         logic v;
         v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
         for (int c = 0; c < cpb; c++) exp_wave.push_back(v);
      end
   endtask

   // Waits (bounded) for the start-bit edge, then compares tx every clock.
   task automatic check_wave(input string name);
      int found;
      int errs;
      int first_bad;
      logic bad_val;
      found = 0;
      errs = 0;
      first_bad = -1;
      bad_val = 1'b0;
      for (int i = 0; i < 80 && found == 0; i++) begin
         @(posedge clk);
         #1;
         if (tx === 1'b0) found = 1;
      end
      checks++;
      if (found == 0) begin
         failures++;
         $display("FAIL %s_start actual=no_start_bit required=start_bit_within_80", name);
      end else begin
         for (int i = 0; i < exp_wave.size(); i++) begin
            if (i > 0) begin
               @(posedge clk);
               #1;
            end
            if (tx !== exp_wave[i]) begin
               if (first_bad < 0) begin
                  first_bad = i;
                  bad_val = tx;
               end
               errs++;
            end
         end
         if (errs != 0) begin
            failures++;
            $display("FAIL %s_wave mismatches=%0d first_cycle=%0d actual=%b required=%b",
                     name, errs, first_bad, bad_val, exp_wave[first_bad]);
         end
      end
      exp_wave.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({tx, wb.wb_ack_o, irq} !== 3'b101) begin
         failures++;
         $display("FAIL reset_outputs actual=%b required=101", {tx, wb.wb_ack_o, irq});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wb_read(2'd1, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++;
         $display("FAIL reset_status actual=%h required=00000001", d);
      end
      wb_read(2'd2, d);
      checks++;
      if (d !== 32'h0000_01B1) begin
         failures++;
         $display("FAIL reset_divisor actual=%h required=000001b1", d);
      end
   endtask

   task automatic test_regs();
      logic [31:0] d;
      logic [3:0]  acks;
      wb_write(2'd2, 32'h1234_5678);
      wb_read(2'd2, d);
      checks++;
      if (d !== 32'h0000_5678) begin
         failures++;
         $display("FAIL divisor_rw actual=%h required=00005678", d);
      end
      wb_write(2'd3, 32'hFFFF_FFFF);
      wb_read(2'd3, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL reserved_read actual=%h required=00000000", d);
      end
      wb_read(2'd0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL txdata_read actual=%h required=00000000", d);
      end
      wb_write(2'd1, 32'hFFFF_FFFF);
      wb_read(2'd1, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++;
         $display("FAIL status_after_regs actual=%h required=00000001", d);
      end
      // Held strobe: ack must alternate, and outside ack cycles dat_o is 0.
      @(negedge clk);
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = 1'b0;
      wb.wb_adr_i = 2'd2;
      for (int i = 3; i >= 0; i--) begin
         @(posedge clk);
         #1;
         acks[i] = wb.wb_ack_o;
      end
      checks++;
      if (wb.wb_dat_o !== 32'h0) begin
         failures++;
         $display("FAIL dat_idle actual=%h required=00000000", wb.wb_dat_o);
      end
      @(negedge clk);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      checks++;
      if (acks !== 4'b1010) begin
         failures++;
         $display("FAIL ack_toggle actual=%b required=1010", acks);
      end
   endtask

   task automatic test_single();
      logic [31:0] d;
      wb_write(2'd2, 32'd3);
      push_frame(8'hA5, 4);
      wb_write(2'd0, 32'h0000_00A5);
      fork
         check_wave("single");
         begin
            repeat (12) @(negedge clk);
            checks++;
            if (irq !== 1'b0) begin
               failures++;
               $display("FAIL single_irq_busy actual=%b required=0", irq);
            end
            wb_read(2'd1, d);
            checks++;
            if (d !== 32'h0000_0005) begin
               failures++;
               $display("FAIL single_status_busy actual=%h required=00000005", d);
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL single_irq_done actual=%b required=1", irq);
      end
   endtask

   task automatic test_back_to_back();
      wb_write(2'd2, 32'd0);
      push_frame(8'h00, 1);
      push_frame(8'hFF, 1);
      wb_write(2'd0, 32'h0000_0000);
      fork
         check_wave("b2b");
         wb_write(2'd0, 32'h0000_00FF);
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL b2b_irq_done actual=%b required=1", irq);
      end
   endtask

   task automatic test_div_change();
      logic [7:0] data;
      data = 8'h55;
      wb_write(2'd2, 32'd7);
      repeat (8) exp_wave.push_back(1'b0);
      for (int b = 1; b < 10; b++) begin
         logic v;
         v = (b == 9) ? 1'b1 : data[b-1];
         repeat (2) exp_wave.push_back(v);
      end
      wb_write(2'd0, 32'h0000_0055);
      fork
         check_wave("divchg");
         wb_write(2'd2, 32'd1);
      join
      repeat (3) @(posedge clk);
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      wb_write(2'd2, 32'd1000);
      for (int i = 0; i < 18; i++) wb_write(2'd0, 32'(8'h30 + i));
      wb_read(2'd1, d);
      checks++;
      if (d !== 32'h0000_100E) begin
         failures++;
         $display("FAIL ovf_status actual=%h required=0000100e", d);
      end
      wb_read(2'd1, d);
      checks++;
      if (d !== 32'h0000_1006) begin
         failures++;
         $display("FAIL ovf_cleared actual=%h required=00001006", d);
      end
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL ovf_irq actual=%b required=0", irq);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      int found;
      int highs_bad;
      found = 0;
      highs_bad = 0;
      wb_write(2'd2, 32'd20);
      for (int i = 0; i < 4; i++) wb_write(2'd0, 32'(8'h11 * (i + 1)));
      for (int i = 0; i < 100 && found == 0; i++) begin
         @(posedge clk);
         #1;
         if (tx === 1'b0) found = 1;
      end
      checks++;
      if (found == 0) begin
         failures++;
         $display("FAIL rstmid_start actual=no_start_bit required=start_bit_within_100");
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({tx, wb.wb_ack_o, irq} !== 3'b101) begin
         failures++;
         $display("FAIL rstmid_outputs actual=%b required=101", {tx, wb.wb_ack_o, irq});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wb_read(2'd1, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++;
         $display("FAIL rstmid_status actual=%h required=00000001", d);
      end
      wb_read(2'd2, d);
      checks++;
      if (d !== 32'h0000_01B1) begin
         failures++;
         $display("FAIL rstmid_divisor actual=%h required=000001b1", d);
      end
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1) highs_bad++;
      end
      checks++;
      if (highs_bad != 0) begin
         failures++;
         $display("FAIL rstmid_quiet low_cycles=%0d required=0", highs_bad);
      end
   endtask

   initial begin
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      wb.wb_adr_i = 2'd0;
      wb.wb_dat_i = 32'd0;
      test_reset();
      test_regs();
      test_single();
      test_back_to_back();
      test_div_change();
      test_overflow();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
